// File: rtl/mem_port_arbiter_pkg.sv
// Shared owner encodings and arbiter defaults for the core and the memory port arbiter.
package mem_port_arbiter_pkg;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_LS   = 2'b10;

  localparam int STARVE_LIMIT_DEFAULT = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// Fetch / load-store priority decision, with an optional fetch starve counter.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch override load-store priority.
import mem_port_arbiter_pkg::*;

module mem_arb_prio #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
`ifdef MEM_ARB_STARVE_GUARD_EN
  input  logic clk,
`endif
  input  logic reset,
  input  logic if_req,
  input  logic ls_req,
  output logic if_gnt,
  output logic ls_gnt
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arb_prio: STARVE_LIMIT must be 1..15");
  end

  logic if_first;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign if_first = (starve_cnt >= LIMIT);

  // Counts consecutive denied fetch cycles; any grant or idle fetch clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= 4'd0;
    else if (if_req && !if_gnt) begin
      if (starve_cnt != 4'hF)
        starve_cnt <= starve_cnt + 4'd1;
    end else
      starve_cnt <= 4'd0;
  end
`else
  assign if_first = 1'b0;
`endif

  always_comb begin
    ls_gnt = !reset && ls_req && !(if_first && if_req);
    if_gnt = !reset && if_req && !ls_gnt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load-store onto one single-port synchronous RAM.
// Optional MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [29:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [1:0] owner_q;
  logic       ls_wr_q;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
`ifdef MEM_ARB_STARVE_GUARD_EN
    .clk    (clk),
`endif
    .reset  (reset),
    .if_req (if_req),
    .ls_req (ls_req),
    .if_gnt (if_gnt),
    .ls_gnt (ls_gnt)
  );

  // Grants already fold in reset, so the command bus is quiet during reset too.
  always_comb begin
    mem_en    = if_gnt || ls_gnt;
    mem_we    = ls_gnt && ls_we;
    mem_be    = 4'h0;
    mem_addr  = 30'd0;
    mem_wdata = 32'd0;
    if (ls_gnt) begin
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_be   = 4'hF;
      mem_addr = if_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      ls_wr_q <= 1'b0;
    end else begin
      owner_q <= ls_gnt ? OWN_LS : (if_gnt ? OWN_IF : OWN_NONE);
      ls_wr_q <= ls_gnt && ls_we;
    end
  end

  // A write completion returns zero data rather than whatever the RAM drives.
  always_comb begin
    if_rvalid = (owner_q == OWN_IF);
    ls_rvalid = (owner_q == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    ls_rdata  = (ls_rvalid && !ls_wr_q) ? mem_rdata : 32'd0;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles fetch may be denied (range 1-15).
REQ-002 SHALL have port clk, input, 1, system clock, rising edge.
REQ-003 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch read request.
REQ-005 SHALL have port if_addr, input, 30, fetch word address [31:2].
REQ-006 SHALL have port if_gnt, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have port if_rvalid / if_rdata, output, 1 / 32, fetch read data valid / data.
REQ-008 SHALL have port ls_req / ls_we, input, 1 / 1, load-store request / write flag.
REQ-009 SHALL have port ls_be / ls_addr / ls_wdata, input, 4 / 30 / 32, byte enables / word address / write data.
REQ-010 SHALL have port ls_gnt / ls_rvalid / ls_rdata, output, 1 / 1 / 32, accepted / completion / read data.
REQ-011 SHALL have port mem_en / mem_we / mem_be / mem_addr / mem_wdata, output, 1 / 1 / 4 / 30 / 32, single-port synchronous RAM command.
REQ-012 SHALL have port mem_rdata, input, 32, RAM read data, valid one cycle after mem_en.

Function
REQ-013 SHALL issue at most one RAM command per cycle; a grant and its mem_en assert in the same cycle, combinationally from the request inputs and state.
REQ-014 SHALL give ls_req priority over if_req when both are asserted, except where REQ-024 applies.
REQ-015 SHALL hold mem_en=0, mem_we=0, mem_be=0 with no grant when neither request is asserted.
REQ-016 SHALL drive mem_we=ls_we and mem_be=ls_be on a load-store grant, and mem_we=0 with mem_be=4'hF on a fetch grant.
REQ-017 SHALL register the owner of each grant and return data exactly one cycle later: if_rvalid (or ls_rvalid) =1 for one cycle, with rdata=mem_rdata.
REQ-018 SHALL assert ls_rvalid one cycle after a write grant as a completion acknowledgment, with ls_rdata=0.
REQ-019 SHALL drive if_rdata and ls_rdata to 0 whenever the corresponding rvalid is 0.
REQ-020 SHALL support back-to-back grants every cycle; a response and a new grant may coincide.
REQ-021 SHALL require requesters to hold req and payload stable until gnt; the arbiter SHALL neither buffer nor retry ungranted requests.
REQ-022 SHALL keep a 4-bit starve counter that increments (saturating at 15) on cycles where if_req=1 and if_gnt=0, and clears on if_gnt or on if_req=0.

Reset
REQ-023 SHALL, while reset=1, force all grants, rvalids, rdata and mem_* outputs to 0, clear the owner register and the starve counter, and drop any in-flight response.

Configuration
REQ-024 SHALL, when the macro MEM_ARB_STARVE_GUARD_EN is defined, grant fetch over load-store when starve counter >= STARVE_LIMIT; without the macro, priority SHALL be strictly load-store-first and the counter SHALL be omitted.

Structure
REQ-025 SHALL take its owner encodings (OWN_NONE=2'b00, OWN_IF=2'b01, OWN_LS=2'b10) and the default STARVE_LIMIT from a shared package header used by core and arbiter.
REQ-026 SHALL implement the starve counter and priority decision in one sub-module, mem_arb_prio.

Verification
REQ-027 SHALL be verified by the following scenario: if_req only, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> if_gnt cycle N, if_rvalid cycle N+1 with if_rdata=0xDEADBEEF.
REQ-028 SHALL be verified by the following scenario: simultaneous if_req and ls_req read at 0x40 -> ls_gnt=1, if_gnt=0, mem_addr=0x40; fetch is granted on the following cycle.
REQ-029 SHALL be verified by the following scenario: ls write, be=4'b0011, wdata=0x12345678 -> mem_we=1, mem_be=0011; ls_rvalid=1 next cycle with ls_rdata=0.
REQ-030 SHALL be verified by the following scenario: with guard enabled and STARVE_LIMIT=4, both requests held continuously -> four ls grants, then one if grant, and the pattern repeats.
REQ-031 SHALL be verified by the following scenario: with guard disabled, both requests held for 20 cycles -> zero if grants.
REQ-032 SHALL be verified by the following scenario: reset asserted in the cycle after a grant -> no rvalid, all outputs 0, and normal operation on the first cycle after deassertion.
